// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the RV32M multiply sequencer: op encodings,
// FSM states, iteration constants and the sign-flag decode.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        CALC   = 3'd3,
        FIX_LO = 3'd4,
        FIX_HI = 3'd5,
        DONE   = 3'd6
    } state_e;

    localparam int DEFAULT_ITER = 32;
    localparam int CNT_W        = 5;

    // Returns {neg_a, neg_b}: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    function automatic logic [1:0] sign_flags(input logic [1:0] op,
                                              input logic       a_msb,
                                              input logic       b_msb);
        logic na;
        logic nb;
        na = a_msb & ((op == OP_MULH) || (op == OP_MULHSU));
        nb = b_msb & (op == OP_MULH);
        return {na, nb};
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply sequencer.
interface mul_seq_ctrl_if;

    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, kill, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/mul_seq_ctrl_adder.sv
// Plain 32-bit ripple adder with carry in/out; the sequencer's only adder.
module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [32:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    assign {co, s} = total;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-and-add multiplier for MUL/MULH/MULHSU/MULHU, sharing one
// adder across operand negation, accumulation and result negation.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int ITER = DEFAULT_ITER
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e            state;
    op_e               op_q;
    logic [31:0]       mcand;
    logic [31:0]       p_hi;
    logic [31:0]       p_lo;
    logic [31:0]       result_q;
    logic              neg_a;
    logic              neg_b;
    logic              neg_r;
    logic              carry;
    logic              done_q;
    logic [CNT_W-1:0]  count;

    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_ci;
    logic [31:0]       add_s;
    logic              add_co;
    logic [1:0]        start_flags;

    assign start_flags = sign_flags(bus.op, bus.a[31], bus.b[31]);

    adder_32bits u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    // Negations are two's complement as ~x + 1; FIX_HI chains FIX_LO's carry.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        case (state)
            NEG_A: begin
                add_a  = ~mcand;
                add_ci = 1'b1;
            end
            NEG_B: begin
                add_a  = ~p_lo;
                add_ci = 1'b1;
            end
            CALC: begin
                add_a = p_hi;
                add_b = p_lo[0] ? mcand : '0;
            end
            FIX_LO: begin
                add_a  = ~p_lo;
                add_ci = 1'b1;
            end
            FIX_HI: begin
                add_a  = ~p_hi;
                add_ci = carry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_MUL;
            mcand    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            result_q <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            neg_r    <= 1'b0;
            carry    <= 1'b0;
            done_q   <= 1'b0;
            count    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && bus.kill) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.kill) begin
                            op_q  <= op_e'(bus.op);
                            mcand <= bus.a;
                            p_lo  <= bus.b;
                            neg_a <= start_flags[1];
                            neg_b <= start_flags[0];
                            neg_r <= start_flags[1] ^ start_flags[0];
                            count <= '0;
                            state <= NEG_A;
                        end
                    end
                    NEG_A: begin
                        if (neg_a) mcand <= add_s;
                        state <= NEG_B;
                    end
                    NEG_B: begin
                        if (neg_b) p_lo <= add_s;
                        p_hi  <= '0;
                        state <= CALC;
                    end
                    CALC: begin
                        // Accumulate into P_hi and shift the whole product right one bit.
                        {p_hi, p_lo} <= {add_co, add_s, p_lo[31:1]};
                        count        <= count + 1'b1;
                        if (count == CNT_LAST) state <= FIX_LO;
                    end
                    FIX_LO: begin
                        carry <= add_co;
                        if (neg_r) p_lo <= add_s;
                        state <= FIX_HI;
                    end
                    FIX_HI: begin
                        if (neg_r) p_hi <= add_s;
                        if (op_q == OP_MUL) result_q <= p_lo;
                        else                result_q <= neg_r ? add_s : p_hi;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl: latency, signed/unsigned
// products, kill, ignored start while busy and asynchronous reset.
module tb_mul_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_seq_ctrl_if bus ();

    mul_seq_ctrl #(.ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from a negedge and returns latency and result at the
    // done cycle's negedge, then steps one more negedge back into IDLE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        int cyc;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        res = bus.result;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        #3;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", bus.done); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h exp 00000000", bus.result); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_timing();
        int cyc;
        int busy_drop;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b exp 0", bus.busy); end
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        busy_drop = 0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise got %b exp 1", bus.busy); end
        while (!bus.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.busy !== 1'b1) busy_drop++;
        end
        checks++;
        if (cyc !== 37) begin errors++; $display("[TB] FAIL mul_latency got %0d exp 37", cyc); end
        checks++;
        if (busy_drop !== 0) begin errors++; $display("[TB] FAIL busy_hold got %0d drops exp 0", busy_drop); end
        checks++;
        if (bus.result !== 32'h0000000F) begin errors++; $display("[TB] FAIL mul_3x5 got %h exp 0000000f", bus.result); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_fall got %b exp 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_unsigned();
        int          lat;
        logic [31:0] res;
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu_ones got %h exp fffffffe", res); end
        checks++;
        if (lat !== 37) begin errors++; $display("[TB] FAIL mulhu_latency got %0d exp 37", lat); end
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== 32'h00000001) begin errors++; $display("[TB] FAIL mul_ones got %h exp 00000001", res); end
        checks++;
        if (lat !== 37) begin errors++; $display("[TB] FAIL mul_ones_latency got %0d exp 37", lat); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops  [5];
        logic [31:0] as   [5];
        logic [31:0] bs   [5];
        logic [31:0] exps [5];
        int          lat;
        logic [31:0] res;
        ops[0] = 2'b01; as[0] = 32'h80000000; bs[0] = 32'h80000000; exps[0] = 32'h40000000;
        ops[1] = 2'b01; as[1] = 32'hFFFFFFFD; bs[1] = 32'h00000005; exps[1] = 32'hFFFFFFFF;
        ops[2] = 2'b00; as[2] = 32'hFFFFFFFD; bs[2] = 32'h00000005; exps[2] = 32'hFFFFFFF1;
        ops[3] = 2'b10; as[3] = 32'hFFFFFFFF; bs[3] = 32'hFFFFFFFF; exps[3] = 32'hFFFFFFFF;
        ops[4] = 2'b01; as[4] = 32'hFFFFFFFF; bs[4] = 32'hFFFFFFFE; exps[4] = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res);
            checks++;
            if (res !== exps[i]) begin
                errors++;
                $display("[TB] FAIL signed_%0d got %h exp %h", i, res, exps[i]);
            end
            checks++;
            if (lat !== 37) begin errors++; $display("[TB] FAIL signed_latency_%0d got %0d exp 37", i, lat); end
        end
    endtask

    task automatic test_kill();
        int          cyc;
        int          early_done;
        int          lat;
        logic [31:0] res;
        logic [31:0] prev;
        prev      = bus.result;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'h00001234;
        bus.b     = 32'h00000010;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        cyc        = 1;
        early_done = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.done) early_done++;
        end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy got %b exp 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0 || early_done !== 0) begin
            errors++;
            $display("[TB] FAIL kill_done got %b (early %0d) exp 0", bus.done, early_done);
        end
        checks++;
        if (bus.result !== prev) begin errors++; $display("[TB] FAIL kill_result got %h exp %h", bus.result, prev); end
        run_op(2'b00, 32'd9, 32'd9, lat, res);
        checks++;
        if (res !== 32'h00000051) begin errors++; $display("[TB] FAIL after_kill got %h exp 00000051", res); end
        checks++;
        if (lat !== 37) begin errors++; $display("[TB] FAIL after_kill_latency got %0d exp 37", lat); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        int pulses;
        int done_cyc;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd100;
        bus.b     = 32'd200;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        pulses    = 0;
        done_cyc  = -1;
        for (cyc = 1; cyc <= 45; cyc++) begin
            if (bus.done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 37) begin
                checks++;
                if (bus.result !== 32'h00004E20) begin
                    errors++;
                    $display("[TB] FAIL busy_start_result got %h exp 00004e20", bus.result);
                end
            end
            bus.start = (cyc == 5 || cyc == 20);
            bus.op    = 2'b11;
            bus.a     = 32'hFFFFFFFF;
            bus.b     = 32'hFFFFFFFF;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (pulses !== 1) begin errors++; $display("[TB] FAIL done_count got %0d exp 1", pulses); end
        checks++;
        if (done_cyc !== 37) begin errors++; $display("[TB] FAIL done_cycle got %0d exp 37", done_cyc); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_ignored got %b exp 0", bus.busy); end
    endtask

    task automatic test_async_reset();
        int          lat;
        logic [31:0] res;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'h0000ABCD;
        bus.b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i < 15; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy got %b exp 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL arst_done got %b exp 0", bus.done); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("[TB] FAIL arst_result got %h exp 00000000", bus.result); end
        #1;
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b00, 32'd7, 32'd6, lat, res);
        checks++;
        if (res !== 32'h0000002A) begin errors++; $display("[TB] FAIL post_reset_mul got %h exp 0000002a", res); end
        checks++;
        if (lat !== 37) begin errors++; $display("[TB] FAIL post_reset_latency got %0d exp 37", lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul_timing();
        test_unsigned();
        test_signed();
        test_kill();
        test_start_ignored();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
